instruction_loader: RTL and testbench

- Writer side of the fetch-stage instruction memory.
- Receives a byte stream from the debug unit (UART receiver), assembles 32-bit instruction words, and issues one-cycle write strobes into instruction memory at sequential word addresses.
- Stops on a HALT word or when memory is full, then reports completion to the debug unit.

---
 rtl/instruction_loader.sv | 120 ++++++++++++
 tb/tb_instruction_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction memory loader. Assembles bytes from the debug unit's UART
// receiver into NB-bit words (MSB first) and writes them into instruction
// memory at sequential word addresses. A load stops after the HALT word has
// been written or when memory is full, and then completion is reported.
//
// Handshake: i_rx_valid is a one-cycle qualifier for i_rx_data, and there
// is no backpressure. Every valid byte is accepted while loading, including
// a byte that arrives in the WRITE cycle. o_wr_enable is a one-cycle
// strobe. o_wr_address and o_wr_data are meaningful only while it is high,
// and they hold their values otherwise.
module instruction_loader #(
  parameter int            NB                = 32,
  parameter int            NB_BYTE           = 8,
  parameter int            N_OF_INSTRUCTIONS = 64,
  parameter logic [NB-1:0] HALT_INSTRUCTION  = 32'hFFFFFFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_wr_enable,
  output logic [NB-1:0]      o_wr_address,
  output logic [NB-1:0]      o_wr_data,
  output logic               o_loading,
  output logic               o_done,
  output logic [NB-1:0]      o_word_count,
  output logic [1:0]         o_state
);

  localparam int IW   = $clog2(N_OF_INSTRUCTIONS);
  localparam int BPW  = NB / NB_BYTE;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(N_OF_INSTRUCTIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state;
  logic [BC_W-1:0] byte_cnt;
  logic [IW-1:0]   word_index;
  logic [NB-1:0]   assembly;
  logic [NB-1:0]   next_asm;
  logic [NB-1:0]   word_addr;

  // Shift in the new byte at the bottom, so the first byte of a word ends up in the top bits.
  assign next_asm  = {assembly[NB-NB_BYTE-1:0], i_rx_data};
  assign word_addr = NB'({word_index, 2'b00});
  assign o_state   = state;

  // Load FSM. All outputs are registered and updated here.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      word_index   <= '0;
      assembly     <= '0;
      o_wr_enable  <= 1'b0;
      o_wr_address <= '0;
      o_wr_data    <= '0;
      o_loading    <= 1'b0;
      o_done       <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_enable <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          // Any byte that arrives together with i_start is dropped.
          if (i_start) begin
            state        <= S_RECEIVE;
            byte_cnt     <= '0;
            word_index   <= '0;
            o_word_count <= '0;
            o_done       <= 1'b0;
            o_loading    <= 1'b1;
          end
        end
        S_RECEIVE: begin
          if (i_rx_valid) begin
            assembly <= next_asm;
            if (byte_cnt == LAST_BYTE) begin
              // Stage the write so the strobe and its data appear together in WRITE.
              byte_cnt     <= '0;
              state        <= S_WRITE;
              o_wr_enable  <= 1'b1;
              o_wr_address <= word_addr;
              o_wr_data    <= next_asm;
              o_word_count <= o_word_count + 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          // A byte in this cycle is the first byte of the next word.
          if (i_rx_valid) begin
            assembly <= next_asm;
            byte_cnt <= BC_W'(1);
          end
          if (assembly == HALT_INSTRUCTION || word_index == LAST_IDX) begin
            state     <= S_DONE;
            o_loading <= 1'b0;
            o_done    <= 1'b1;
          end else begin
            word_index <= word_index + 1'b1;
            state      <= S_RECEIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader. Directed byte streams drive the design.
// A monitor compares every write strobe against a queue of expected writes
// ({address, data, word_count}) that the stimulus pushes.
module tb_instruction_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_enable;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic        loading;
  logic        done;
  logic [31:0] word_count;
  logic [1:0]  state;

  logic [95:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_we = 1'b0;

  instruction_loader dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_wr_enable  (wr_enable),
    .o_wr_address (wr_address),
    .o_wr_data    (wr_data),
    .o_loading    (loading),
    .o_done       (done),
    .o_word_count (word_count),
    .o_state      (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: all driving happens 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Send one word, MSB byte first. If gap is set, an idle cycle follows each byte.
  // When a write is expected, push its address, data and count.
  task automatic send_word(input logic [31:0] w, input bit gap, input bit exp_wr,
                           input logic [31:0] exp_addr, input logic [31:0] exp_cnt);
    if (exp_wr) exp_q.push_back({exp_addr, w, exp_cnt});
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      if (gap) idle(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    {31'd0, wr_enable}, 32'd0);
    check({tag, "_addr"},  wr_address,         32'd0);
    check({tag, "_data"},  wr_data,            32'd0);
    check({tag, "_load"},  {31'd0, loading},   32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_count"}, word_count,         32'd0);
    check({tag, "_state"}, {30'd0, state},     32'd0);
  endtask

  // Scoreboard monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_enable) begin
        if (prev_we) check("strobe_single_cycle", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_addr", wr_address, 32'hDEAD_BEEF);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          check("wr_address", wr_address, e[95:64]);
          check("wr_data", wr_data, e[63:32]);
          check("wr_count", word_count, e[31:0]);
          check("wr_loading", {31'd0, loading}, 32'd1);
        end
      end
      prev_we = wr_enable;
    end else begin
      prev_we = 1'b0;
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Bytes are ignored while idle
    send_word(32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(2);
    check("idle_count", word_count, 32'd0);

    // First word, with gaps between bytes
    pulse_start();
    check("start_loading", {31'd0, loading}, 32'd1);
    send_word(32'h20010005, 1'b1, 1'b1, 32'd0, 32'd1);
    // Two more words, then HALT
    send_word(32'hA5A5_0001, 1'b1, 1'b1, 32'd4, 32'd2);
    send_word(32'h0000_00FF, 1'b0, 1'b1, 32'd8, 32'd3);
    idle(1);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b1, 32'd12, 32'd4);
    idle(3);
    check_drained("halt_drained");
    check("halt_done", {31'd0, done}, 32'd1);
    check("halt_loading", {31'd0, loading}, 32'd0);
    check("halt_count", word_count, 32'd4);
    check("halt_state", {30'd0, state}, 32'd3);
    // Bytes in DONE produce no strobes
    send_word(32'h1111_2222, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(3);
    check("done_ignore_count", word_count, 32'd4);

    // Start together with a byte: the byte is dropped, the load clears the flags
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_count", word_count, 32'd0);
    // Fill memory: 64 back-to-back words, none of them HALT
    for (int i = 0; i < 64; i++)
      send_word(32'h1000_0000 + 32'(i), 1'b0, 1'b1, 32'(i * 4), 32'(i + 1));
    idle(3);
    check_drained("full_drained");
    check("full_done", {31'd0, done}, 32'd1);
    check("full_count", word_count, 32'd64);
    check("full_loading", {31'd0, loading}, 32'd0);
    check("full_last_addr", wr_address, 32'd252);
    send_word(32'h3333_4444, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(3);
    check("full_ignore_count", word_count, 32'd64);

    // Back-to-back words: the fifth byte arrives in the WRITE cycle
    pulse_start();
    send_word(32'hCAFE_0001, 1'b0, 1'b1, 32'd0, 32'd1);
    send_word(32'hBEEF_0002, 1'b0, 1'b1, 32'd4, 32'd2);
    idle(2);
    // Start in the middle of a word has no effect
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    exp_q.push_back({32'd8, 32'h0102_0304, 32'd3});
    send_byte(8'h03);
    send_byte(8'h04);
    idle(2);
    check("midstart_loading", {31'd0, loading}, 32'd1);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b1, 32'd12, 32'd4);
    idle(3);
    check_drained("b2b_drained");
    check("b2b_done", {31'd0, done}, 32'd1);

    // Reset in the middle of a word: outputs clear at once, no strobe
    pulse_start();
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    pulse_start();
    send_word(32'h0BAD_F00D, 1'b1, 1'b1, 32'd0, 32'd1);
    idle(3);
    check_drained("post_reset_drained");
    check("post_reset_count", word_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
